// File: rtl/lpc_stream_scheduler_pkg.sv
// Shared definitions for the LPC stream scheduler: cycle encodings, record layout, FSM states.
package lpc_stream_scheduler_pkg;

  localparam logic [3:0] CT_IO_RD  = 4'b0000;
  localparam logic [3:0] CT_IO_WR  = 4'b0010;
  localparam logic [3:0] CT_MEM_RD = 4'b0100;
  localparam logic [3:0] CT_MEM_WR = 4'b0110;

  localparam logic [7:0] OVF_MARKER = 8'hFF;
  localparam int         REC_W      = 71;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REC_HDR  = 3'd1,
    ST_REC_ADDR = 3'd2,
    ST_REC_DATA = 3'd3,
    ST_OVF_HDR  = 3'd4,
    ST_OVF_CNT  = 3'd5
  } sched_state_t;

  typedef struct packed {
    logic [3:0]  cyctype_dir;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
  } lpc_rec_t;

  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > 3'd4) ? 3'd4 : size;
  endfunction

endpackage

// File: rtl/lpc_rec_fifo.sv
// Synchronous record FIFO; pop loads rd_data, which is valid the cycle after pop.
module lpc_rec_fifo
  import lpc_stream_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = REC_W
) (
  input  logic                     lpc_clock,
  input  logic                     lpc_reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge lpc_clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/lpc_stream_scheduler.sv
// Buffers decoded LPC records and serializes them, plus overflow reports, into a byte stream.
// state    | meaning
// IDLE     | frame boundary; overflow frame wins, else pop the next record
// REC_HDR  | record header {ct_dir[3:1], 2'b00, size}
// REC_ADDR | address byte idx, 3 down to 0
// REC_DATA | data byte idx, 0 up to size-1
// OVF_HDR  | overflow marker 8'hFF
// OVF_CNT  | drop count captured on OVF_HDR entry
module lpc_stream_scheduler
  import lpc_stream_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 8
) (
  input  logic                          lpc_clock,
  input  logic                          lpc_reset,
  input  logic                          in_valid,
  input  logic [3:0]                    in_cyctype_dir,
  input  logic [31:0]                   in_addr,
  input  logic [31:0]                   in_data,
  input  logic [2:0]                    in_data_size,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          drop_pending
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  sched_state_t        state, state_nx;
  logic [1:0]          idx, idx_nx;
  logic [DROP_W-1:0]   drop_cnt, ovf_cnt;
  logic [DROP_W+7:0]   ovf_ext;
  logic [7:0]          ovf_byte;
  lpc_rec_t            in_rec, rec;
  logic                fifo_full, fifo_empty;
  logic [LW-1:0]       level;
  logic                pop, snap, drop, xfer;
  logic                unused_ct_lsb;

  assign in_rec = {in_cyctype_dir, in_addr, in_data, clamp_size(in_data_size)};

  lpc_rec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_rec_fifo (
    .lpc_clock (lpc_clock),
    .lpc_reset (lpc_reset),
    .push      (in_valid),
    .wr_data   (in_rec),
    .pop       (pop),
    .rd_data   (rec),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign drop          = in_valid & fifo_full;
  assign fifo_level    = level;
  assign drop_pending  = (drop_cnt != '0);
  assign tx_valid      = (state != ST_IDLE);
  assign xfer          = tx_valid & tx_ready;
  assign unused_ct_lsb = rec.cyctype_dir[0];

  // Counts wider than one byte are reported as 8'hFF once they exceed 255.
  assign ovf_ext  = {8'h00, ovf_cnt};
  assign ovf_byte = (ovf_ext[DROP_W+7:8] != '0) ? 8'hFF : ovf_ext[7:0];

  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (snap) begin
        ovf_cnt  <= drop_cnt;
        drop_cnt <= drop ? DROP_W'(1) : '0;
      end else if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    pop      = 1'b0;
    snap     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (drop_cnt != '0) begin
          state_nx = ST_OVF_HDR;
          snap     = 1'b1;
        end else if (!fifo_empty) begin
          state_nx = ST_REC_HDR;
          pop      = 1'b1;
        end
      end
      ST_REC_HDR: begin
        if (xfer) begin
          state_nx = ST_REC_ADDR;
          idx_nx   = 2'd3;
        end
      end
      ST_REC_ADDR: begin
        if (xfer) begin
          if (idx != 2'd0) begin
            idx_nx = idx - 2'd1;
          end else if (rec.size == 3'd0) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_REC_DATA;
            idx_nx   = 2'd0;
          end
        end
      end
      ST_REC_DATA: begin
        if (xfer) begin
          if ({1'b0, idx} == (rec.size - 3'd1)) begin
            state_nx = ST_IDLE;
          end else begin
            idx_nx = idx + 2'd1;
          end
        end
      end
      ST_OVF_HDR: begin
        if (xfer) begin
          state_nx = ST_OVF_CNT;
        end
      end
      ST_OVF_CNT: begin
        if (xfer) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_data = '0;
    case (state)
      ST_REC_HDR:  tx_data = {rec.cyctype_dir[3:1], 2'b00, rec.size};
      ST_REC_ADDR: tx_data = rec.addr[{idx, 3'b000} +: 8];
      ST_REC_DATA: tx_data = rec.data[{idx, 3'b000} +: 8];
      ST_OVF_HDR:  tx_data = OVF_MARKER;
      ST_OVF_CNT:  tx_data = ovf_byte;
      default:     tx_data = '0;
    endcase
  end

endmodule

// File: tb/tb_lpc_stream_scheduler.sv
// Directed bench for lpc_stream_scheduler: frame bytes, backpressure, overflow, saturation, reset.
module tb_lpc_stream_scheduler;
  import lpc_stream_scheduler_pkg::*;

  logic        clk;
  logic        lpc_reset;
  logic        in_valid;
  logic [3:0]  in_cyctype_dir;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [2:0]  in_data_size;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [2:0]  fifo_level;
  logic        drop_pending;

  int errors = 0;
  int checks = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         cyc_q[$];

  lpc_stream_scheduler #(
    .FIFO_DEPTH (4),
    .DROP_W     (8)
  ) dut (
    .lpc_clock      (clk),
    .lpc_reset      (lpc_reset),
    .in_valid       (in_valid),
    .in_cyctype_dir (in_cyctype_dir),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_data_size   (in_data_size),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .fifo_level     (fifo_level),
    .drop_pending   (drop_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Push one record at the next rising edge; returns at the following falling edge.
  task automatic drive(input logic [3:0] ct, input logic [31:0] addr,
                       input logic [31:0] data, input logic [2:0] size);
    in_valid       = 1'b1;
    in_cyctype_dir = ct;
    in_addr        = addr;
    in_data        = data;
    in_data_size   = size;
    @(negedge clk);
  endtask

  task automatic add_rec_frame(input logic [3:0] ct, input logic [31:0] addr,
                               input logic [31:0] data, input logic [2:0] size);
    int sc;
    sc = (size > 3'd4) ? 4 : int'(size);
    exp_q.push_back({ct[3:1], 2'b00, 3'(sc)});
    for (int b = 3; b >= 0; b--) exp_q.push_back(addr[b*8 +: 8]);
    for (int b = 0; b < sc; b++) exp_q.push_back(data[b*8 +: 8]);
  endtask

  task automatic run_tx(input int n, input int budget, input bit toggle);
    int         cyc;
    bit         hold;
    logic [7:0] held;
    logic       r;
    cyc  = 0;
    hold = 1'b0;
    held = '0;
    got_q.delete();
    cyc_q.delete();
    while (got_q.size() < n && cyc < budget) begin
      @(negedge clk);
      if (hold) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(held));
      end
      r = toggle ? (cyc % 3 == 0) : 1'b1;
      tx_ready = r;
      if (tx_valid && r) begin
        got_q.push_back(tx_data);
        cyc_q.push_back(cyc);
      end
      hold = tx_valid && !r;
      held = tx_data;
      cyc++;
    end
    chk("tx_count", got_q.size(), n);
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic cmp_frame(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    lpc_reset      = 1'b1;
    in_valid       = 1'b0;
    in_cyctype_dir = '0;
    in_addr        = '0;
    in_data        = '0;
    in_data_size   = '0;
    tx_ready       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_drop", 32'(drop_pending), 32'd0);
    lpc_reset = 1'b0;
    @(negedge clk);

    // Single mem-read record, latency to header
    drive(CT_MEM_RD, 32'haffe7fe5, 32'h0000df6c, 3'd2);
    in_valid = 1'b0;
    chk("t1_lat1_valid", 32'(tx_valid), 32'd0);
    chk("t1_lat1_level", 32'(fifo_level), 32'd1);
    @(negedge clk);
    chk("t1_lat2_valid", 32'(tx_valid), 32'd1);
    chk("t1_lat2_hdr", 32'(tx_data), 32'h42);
    chk("t1_lat2_level", 32'(fifo_level), 32'd0);
    run_tx(7, 50, 1'b0);
    exp_q = '{8'h42, 8'hAF, 8'hFE, 8'h7F, 8'hE5, 8'h6C, 8'hDF};
    cmp_frame("t1");
    chk("t1_end_valid", 32'(tx_valid), 32'd0);
    chk("t1_end_level", 32'(fifo_level), 32'd0);

    // Same record under 1,0,0 backpressure
    drive(CT_MEM_RD, 32'haffe7fe5, 32'h0000df6c, 3'd2);
    in_valid = 1'b0;
    run_tx(7, 100, 1'b1);
    cmp_frame("t2");
    chk("t2_end_valid", 32'(tx_valid), 32'd0);

    // Size 0 and clamped size 7, back to back
    drive(CT_IO_WR, 32'h12345678, 32'hdeadbeef, 3'd0);
    drive(CT_MEM_WR, 32'hcafef00d, 32'h44332211, 3'd7);
    in_valid = 1'b0;
    run_tx(14, 100, 1'b0);
    exp_q = '{8'h20, 8'h12, 8'h34, 8'h56, 8'h78,
              8'h64, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h44};
    cmp_frame("tsz");
    if (cyc_q.size() == 14) begin
      chk("tsz_burst", 32'(cyc_q[4] - cyc_q[0]), 32'd4);
      chk("tsz_gap", 32'(cyc_q[5] - cyc_q[4]), 32'd2);
    end

    // Overflow: record 0 is popped the cycle after its push, 1..4 fill the FIFO, 5 and 6 drop
    for (int i = 0; i < 7; i++) drive(CT_MEM_RD, 32'(i), 32'(8'hA0 + i), 3'd1);
    in_valid = 1'b0;
    chk("t3_level", 32'(fifo_level), 32'd4);
    chk("t3_drop", 32'(drop_pending), 32'd1);
    chk("t3_hdr", 32'(tx_data), 32'h41);
    exp_q.delete();
    add_rec_frame(CT_MEM_RD, 32'd0, 32'hA0, 3'd1);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h02);
    for (int i = 1; i < 5; i++) add_rec_frame(CT_MEM_RD, 32'(i), 32'(8'hA0 + i), 3'd1);
    run_tx(32, 200, 1'b0);
    cmp_frame("t3");
    chk("t3_end_drop", 32'(drop_pending), 32'd0);
    chk("t3_end_level", 32'(fifo_level), 32'd0);

    // Saturation: 300 drops report as FF FF
    for (int i = 0; i < 305; i++) drive(CT_MEM_RD, 32'(i), 32'h5A, 3'd1);
    in_valid = 1'b0;
    chk("tsat_drop", 32'(drop_pending), 32'd1);
    exp_q.delete();
    add_rec_frame(CT_MEM_RD, 32'd0, 32'h5A, 3'd1);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    run_tx(8, 100, 1'b0);
    cmp_frame("tsat");
    lpc_reset = 1'b1;
    @(negedge clk);
    lpc_reset = 1'b0;
    chk("tsat_rst_level", 32'(fifo_level), 32'd0);

    // Reset mid-frame with a full FIFO and pending drops
    drive(CT_MEM_RD, 32'haffe7fe5, 32'h0000df6c, 3'd2);
    in_valid = 1'b0;
    run_tx(3, 50, 1'b0);
    chk("trst_byte4", 32'(tx_data), 32'h7F);
    for (int i = 0; i < 6; i++) drive(CT_IO_RD, 32'(i), 32'h0, 3'd1);
    in_valid = 1'b0;
    chk("trst_pre_level", 32'(fifo_level), 32'd4);
    chk("trst_pre_drop", 32'(drop_pending), 32'd1);
    chk("trst_pre_hold", 32'(tx_data), 32'h7F);
    lpc_reset = 1'b1;
    @(negedge clk);
    lpc_reset = 1'b0;
    chk("trst_valid", 32'(tx_valid), 32'd0);
    chk("trst_data", 32'(tx_data), 32'd0);
    chk("trst_level", 32'(fifo_level), 32'd0);
    chk("trst_drop", 32'(drop_pending), 32'd0);
    drive(CT_IO_RD, 32'h0badbeef, 32'h0, 3'd0);
    in_valid = 1'b0;
    run_tx(5, 50, 1'b0);
    exp_q = '{8'h00, 8'h0B, 8'hAD, 8'hBE, 8'hEF};
    cmp_frame("trst");
    chk("trst_end_valid", 32'(tx_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
